// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern controller.
//   mode_t     : 2-bit mode encoding driven on the controller's mode port
//   next_mode  : short-press mode sequence OFF -> ON -> BLINK -> CHASE -> OFF
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CHASE = 2'd3
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_OFF:   next_mode = MODE_ON;
      MODE_ON:    next_mode = MODE_BLINK;
      MODE_BLINK: next_mode = MODE_CHASE;
      default:    next_mode = MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Button input conditioning: 2-flop synchroniser, debounce counter and hold
// counter. Emits single-cycle pulses for completed short presses and for a
// hold reaching LONG_PRESS_CYC.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_button  : raw active-high button, asynchronous to clk
//   short_press  : 1-cycle pulse after a debounced release of a short hold
//   long_press   : 1-cycle pulse when the debounced hold reaches LONG_PRESS_CYC
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYC   = 500_000,
  parameter int unsigned LONG_PRESS_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_button,
  output logic short_press,
  output logic long_press
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int unsigned HW = $clog2(LONG_PRESS_CYC) + 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic          db_flip;
  logic          fall;

  // The current cycle is the DEBOUNCE_CYC-th consecutive differing cycle.
  assign db_flip = (sync2 != level) && (db_cnt == DW'(DEBOUNCE_CYC - 1));
  assign fall    = db_flip && level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      level       <= 1'b0;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      sync1 <= push_button;
      sync2 <= sync1;

      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        db_cnt <= '0;
        level  <= sync2;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end

      if (!level) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HW'(LONG_PRESS_CYC)) begin
        hold_cnt <= hold_cnt + HW'(1);
      end

      // A release that coincides with the hold reaching its limit counts as
      // short; the long pulse is suppressed on a falling cycle so that at
      // most one of the two fires for a given press.
      short_press <= fall && (hold_cnt < HW'(LONG_PRESS_CYC));
      long_press  <= level && !fall && (hold_cnt == HW'(LONG_PRESS_CYC - 1));
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Push-button LED bank controller. A short press cycles the mode
// OFF -> ON -> BLINK -> CHASE -> OFF; a long press forces OFF.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_button  : raw active-high button, asynchronous to clk
//   leds         : registered LED drive, active-high, NUM_LEDS wide
//   mode         : registered current mode (0 OFF, 1 ON, 2 BLINK, 3 CHASE)
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned NUM_LEDS       = 4,
  parameter int unsigned DEBOUNCE_CYC   = 500_000,
  parameter int unsigned TICK_CYC       = 12_500_000,
  parameter int unsigned LONG_PRESS_CYC = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_button,
  output logic [NUM_LEDS-1:0] leds,
  output logic [1:0]          mode
);

  localparam int unsigned TW = $clog2(TICK_CYC);

  if (CLK_HZ == 0 || NUM_LEDS < 1 || DEBOUNCE_CYC < 1 || TICK_CYC < 2 ||
      LONG_PRESS_CYC <= DEBOUNCE_CYC) begin : g_bad_params
    $error("led_pattern_ctrl: illegal parameter combination");
  end

  logic                short_press;
  logic                long_press;
  mode_t               state;
  mode_t               state_next;
  logic [TW-1:0]       tick;
  logic [TW-1:0]       tick_next;
  logic [NUM_LEDS-1:0] leds_next;
  logic                entry;
  logic                step;

  button_debounce #(
    .DEBOUNCE_CYC   (DEBOUNCE_CYC),
    .LONG_PRESS_CYC (LONG_PRESS_CYC)
  ) u_button_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_button (push_button),
    .short_press (short_press),
    .long_press  (long_press)
  );

  function automatic logic [NUM_LEDS-1:0] entry_pattern(input mode_t m);
    case (m)
      MODE_ON, MODE_BLINK: entry_pattern = '1;
      MODE_CHASE:          entry_pattern = NUM_LEDS'(1);
      default:             entry_pattern = '0;
    endcase
  endfunction

  assign mode = state;
  assign step = (tick == TW'(TICK_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MODE_OFF;
      tick  <= '0;
      leds  <= '0;
    end else begin
      state <= state_next;
      tick  <= tick_next;
      leds  <= leds_next;
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = '0;
    leds_next  = leds;
    entry      = 1'b0;

    if (long_press) begin
      state_next = MODE_OFF;
      entry      = 1'b1;
    end else if (short_press) begin
      state_next = next_mode(state);
      entry      = 1'b1;
    end

    // Mode entry takes priority over a coincident tick: reinitialise, no step.
    if (entry) begin
      leds_next = entry_pattern(state_next);
    end else begin
      case (state)
        MODE_OFF: leds_next = '0;
        MODE_ON:  leds_next = '1;
        MODE_BLINK: begin
          tick_next = step ? '0 : tick + TW'(1);
          if (step) leds_next = ~leds;
        end
        default: begin
          tick_next = step ? '0 : tick + TW'(1);
          // Rotate left; for a single LED this degenerates to a constant 1.
          if (step) leds_next = (leds << 1) | (leds >> (NUM_LEDS - 1));
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push_button = 1'b0;
  logic [3:0] leds;
  logic [1:0] mode;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  led_pattern_ctrl #(
    .CLK_HZ         (100),
    .NUM_LEDS       (4),
    .DEBOUNCE_CYC   (4),
    .TICK_CYC       (8),
    .LONG_PRESS_CYC (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_button (push_button),
    .leds        (leds),
    .mode        (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold 10 cycles, release; mode must change on the 7th edge after release
  // (release first sampled at edge k, change at k+6).
  task automatic short_press(input logic [1:0] from_m, input logic [1:0] to_m);
    push_button = 1'b1;
    step(10);
    push_button = 1'b0;
    step(6);
    check("mode_before_change", 32'(mode), 32'(from_m));
    step(1);
    check("mode_after_change", 32'(mode), 32'(to_m));
  endtask

  initial begin
    step(2);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 100; i++) begin
      check("reset_mode", 32'(mode), 32'd0);
      check("reset_leds", 32'(leds), 32'h0);
      step(1);
    end

    // OFF -> ON
    short_press(2'd0, 2'd1);
    check("on_leds", 32'(leds), 32'hF);
    step(13);

    // Glitch shorter than the debounce window
    push_button = 1'b1;
    step(3);
    push_button = 1'b0;
    step(20);
    check("glitch_mode", 32'(mode), 32'd1);
    check("glitch_leds", 32'(leds), 32'hF);

    // ON -> BLINK
    short_press(2'd1, 2'd2);
    check("blink_entry", 32'(leds), 32'hF);
    step(7);
    check("blink_pre_tick", 32'(leds), 32'hF);
    step(1);
    check("blink_tick1", 32'(leds), 32'h0);
    step(8);
    check("blink_tick2", 32'(leds), 32'hF);
    step(4);

    // BLINK -> CHASE
    short_press(2'd2, 2'd3);
    check("chase_entry", 32'(leds), 32'h1);
    step(7);
    check("chase_pre_tick", 32'(leds), 32'h1);
    step(1);
    check("chase_tick1", 32'(leds), 32'h2);
    step(8);
    check("chase_tick2", 32'(leds), 32'h4);
    step(8);
    check("chase_tick3", 32'(leds), 32'h8);
    step(8);
    check("chase_wrap", 32'(leds), 32'h1);
    step(4);

    // CHASE -> OFF wraps
    short_press(2'd3, 2'd0);
    check("off_leds", 32'(leds), 32'h0);
    step(13);

    short_press(2'd0, 2'd1);
    step(13);
    short_press(2'd1, 2'd2);
    step(13);
    short_press(2'd2, 2'd3);
    step(13);

    // Long press in CHASE: press sampled at k, debounced rise at k+5,
    // OFF at k+38.
    push_button = 1'b1;
    step(38);
    check("long_before", 32'(mode), 32'd3);
    step(1);
    check("long_mode", 32'(mode), 32'd0);
    check("long_leds", 32'(leds), 32'h0);
    step(1);
    push_button = 1'b0;
    step(30);
    check("long_release_mode", 32'(mode), 32'd0);
    check("long_release_leds", 32'(leds), 32'h0);

    // Reset in the middle of a press while in BLINK
    short_press(2'd0, 2'd1);
    step(13);
    short_press(2'd1, 2'd2);
    step(3);
    push_button = 1'b1;
    step(3);
    rst_n = 1'b0;
    #1;
    check("rst_async_mode", 32'(mode), 32'd0);
    check("rst_async_leds", 32'(leds), 32'h0);
    step(2);
    check("rst_held_mode", 32'(mode), 32'd0);
    rst_n = 1'b1;
    step(10);
    check("rst_hold_mode", 32'(mode), 32'd0);
    push_button = 1'b0;
    step(20);
    check("rst_new_press_mode", 32'(mode), 32'd1);
    check("rst_new_press_leds", 32'(leds), 32'hF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
